xunit_msg_sched: RTL and testbench

//  Parametrised SHA-2 message-schedule functional unit for the Versat datapath.

---
 rtl/sha2_pkg.sv | 44 ++++
 rtl/sha2_sched_sigma.sv | 35 +++
 rtl/xunit_msg_sched.sv | 134 +++++++++++++
 tb/tb_xunit_msg_sched.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha2_pkg.sv
// Shared SHA-2 message-schedule definitions: FSM encoding, sigma rotate/shift amounts
// and width-parametrised ROTR/SHR helpers (operands right-aligned in 64 bits).
package sha2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_LOAD   = 2'd2,
    ST_EXPAND = 2'd3
  } state_t;

  localparam int unsigned WIN = 16;

  localparam int unsigned S0_R1_32 = 7;
  localparam int unsigned S0_R2_32 = 18;
  localparam int unsigned S0_SH_32 = 3;
  localparam int unsigned S1_R1_32 = 17;
  localparam int unsigned S1_R2_32 = 19;
  localparam int unsigned S1_SH_32 = 10;

  localparam int unsigned S0_R1_64 = 1;
  localparam int unsigned S0_R2_64 = 8;
  localparam int unsigned S0_SH_64 = 7;
  localparam int unsigned S1_R1_64 = 19;
  localparam int unsigned S1_R2_64 = 61;
  localparam int unsigned S1_SH_64 = 6;

  function automatic logic [63:0] wmask(input int unsigned w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n,
                                       input int unsigned w);
    logic [63:0] y;
    y = x & wmask(w);
    return ((y >> n) | (y << (w - n))) & wmask(w);
  endfunction

  function automatic logic [63:0] shr(input logic [63:0] x, input int unsigned n,
                                      input int unsigned w);
    return (x & wmask(w)) >> n;
  endfunction

endpackage

// File: rtl/sha2_sched_sigma.sv
// Combinational SHA-2 schedule step: s = sig1(w14) + w9 + sig0(w1) + w0 mod 2^DATA_W.
module sha2_sched_sigma
  import sha2_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] w0,
  input  logic [DATA_W-1:0] w1,
  input  logic [DATA_W-1:0] w9,
  input  logic [DATA_W-1:0] w14,
  output logic [DATA_W-1:0] s
);

  logic [DATA_W-1:0] sig0;
  logic [DATA_W-1:0] sig1;

  if (DATA_W == 64) begin : g_w64
    always_comb begin
      sig0 = DATA_W'(rotr(64'(w1), S0_R1_64, 64) ^ rotr(64'(w1), S0_R2_64, 64)
                     ^ shr(64'(w1), S0_SH_64, 64));
      sig1 = DATA_W'(rotr(64'(w14), S1_R1_64, 64) ^ rotr(64'(w14), S1_R2_64, 64)
                     ^ shr(64'(w14), S1_SH_64, 64));
    end
  end else begin : g_w32
    always_comb begin
      sig0 = DATA_W'(rotr(64'(w1), S0_R1_32, 32) ^ rotr(64'(w1), S0_R2_32, 32)
                     ^ shr(64'(w1), S0_SH_32, 32));
      sig1 = DATA_W'(rotr(64'(w14), S1_R1_32, 32) ^ rotr(64'(w14), S1_R2_32, 32)
                     ^ shr(64'(w14), S1_SH_32, 32));
    end
  end

  assign s = sig1 + w9 + sig0 + w0;

endmodule

// File: rtl/xunit_msg_sched.sv
// SHA-2 message-schedule unit: loads 16 words per block, then expands to ROUNDS words,
// one registered word per cycle, with optional start delay and multi-block chaining.
module xunit_msg_sched
  import sha2_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ROUNDS  = 64,
  parameter int unsigned DELAY_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               done,
  input  logic [DATA_W-1:0]  in0,
  output logic [DATA_W-1:0]  out0,
  output logic               valid,
  input  logic [DELAY_W-1:0] delay0,
  input  logic [7:0]         blocks0
);

  localparam int unsigned RND_W = $clog2(ROUNDS);
  localparam int unsigned BLK_W = 8;

  state_t             state;
  state_t             state_nx;
  logic [RND_W-1:0]   rnd;
  logic [RND_W-1:0]   rnd_nx;
  logic [BLK_W-1:0]   blk;
  logic [BLK_W-1:0]   blk_nx;
  logic [DELAY_W-1:0] dly;
  logic [DELAY_W-1:0] dly_nx;
  logic [DATA_W-1:0]  win [WIN];
  logic [DATA_W-1:0]  sched_c;
  logic [DATA_W-1:0]  word_c;
  logic [DATA_W-1:0]  out_nx;
  logic               shift_c;
  logic               valid_nx;
  logic               done_nx;

  sha2_sched_sigma #(.DATA_W(DATA_W)) u_sigma (
    .w0  (win[0]),
    .w1  (win[1]),
    .w9  (win[9]),
    .w14 (win[14]),
    .s   (sched_c)
  );

  // run has priority in every state so a busy unit restarts cleanly
  always_comb begin
    state_nx = state;
    rnd_nx   = rnd;
    blk_nx   = blk;
    dly_nx   = dly;
    shift_c  = 1'b0;
    word_c   = in0;
    out_nx   = out0;
    valid_nx = 1'b0;
    if (run) begin
      dly_nx   = delay0;
      blk_nx   = (blocks0 == '0) ? BLK_W'(1) : blocks0;
      rnd_nx   = '0;
      state_nx = (delay0 != '0) ? ST_DELAY : ST_LOAD;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nx = ST_IDLE;
        end
        ST_DELAY: begin
          dly_nx = dly - DELAY_W'(1);
          if (dly == DELAY_W'(1)) state_nx = ST_LOAD;
        end
        ST_LOAD: begin
          shift_c  = 1'b1;
          word_c   = in0;
          out_nx   = in0;
          valid_nx = 1'b1;
          rnd_nx   = rnd + RND_W'(1);
          if (rnd == RND_W'(WIN - 1)) state_nx = ST_EXPAND;
        end
        ST_EXPAND: begin
          shift_c  = 1'b1;
          word_c   = sched_c;
          out_nx   = sched_c;
          valid_nx = 1'b1;
          if (rnd == RND_W'(ROUNDS - 1)) begin
            rnd_nx = '0;
            if (blk > BLK_W'(1)) begin
              blk_nx   = blk - BLK_W'(1);
              state_nx = ST_LOAD;
            end else begin
              blk_nx   = '0;
              state_nx = ST_IDLE;
            end
          end else begin
            rnd_nx = rnd + RND_W'(1);
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
    done_nx = (state_nx == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      rnd   <= '0;
      blk   <= '0;
      dly   <= '0;
      out0  <= '0;
      valid <= 1'b0;
      done  <= 1'b1;
    end else begin
      state <= state_nx;
      rnd   <= rnd_nx;
      blk   <= blk_nx;
      dly   <= dly_nx;
      out0  <= out_nx;
      valid <= valid_nx;
      done  <= done_nx;
    end
  end

  // 16-word sliding window; w[15] is the newest word
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(WIN); i++) win[i] <= '0;
    end else if (shift_c) begin
      for (int i = 0; i < int'(WIN) - 1; i++) win[i] <= win[i+1];
      win[WIN-1] <= word_c;
    end
  end

endmodule

// File: tb/tb_xunit_msg_sched.sv
// Bench for xunit_msg_sched: plans a cycle timeline of stimulus and expected outputs from the
// SHA-2 schedule recurrence, then replays it against a 32-bit and a 64-bit instance.
module tb_xunit_msg_sched;

  localparam int NC = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, run_a, done_a, valid_a;
  logic [31:0] in_a, dly_a, out_a;
  logic [7:0]  blk_a;
  logic        rst_b, run_b, done_b, valid_b;
  logic [63:0] in_b, out_b;
  logic [31:0] dly_b;
  logic [7:0]  blk_b;

  xunit_msg_sched #(.DATA_W(32), .ROUNDS(64), .DELAY_W(32)) u_a (
    .clk(clk), .rst(rst_a), .run(run_a), .done(done_a), .in0(in_a), .out0(out_a),
    .valid(valid_a), .delay0(dly_a), .blocks0(blk_a)
  );

  xunit_msg_sched #(.DATA_W(64), .ROUNDS(80), .DELAY_W(32)) u_b (
    .clk(clk), .rst(rst_b), .run(run_b), .done(done_b), .in0(in_b), .out0(out_b),
    .valid(valid_b), .delay0(dly_b), .blocks0(blk_b)
  );

  // timeline: stimulus for cycle c is sampled at the c-th rising edge; expected outputs
  // for cycle c are what the DUT shows after the (c-1)-th rising edge
  logic        drst [NC];
  logic        drun [NC];
  logic [63:0] din  [NC];
  logic [31:0] ddly [NC];
  logic [7:0]  dblk [NC];
  logic        ev   [NC];
  logic        edone[NC];
  logic        ezero[NC];
  logic [63:0] ew   [NC];
  logic [63:0] eout [NC];

  logic [63:0] bw [4][16];
  logic [63:0] sw [128];
  int wide, rounds, vectors, errors;

  function automatic logic [63:0] msk(input logic [63:0] x);
    return (wide != 0) ? x : (x & 64'hFFFF_FFFF);
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    logic [63:0] y;
    y = msk(x);
    if (wide != 0) return (y >> n) | (y << (64 - n));
    return msk((y >> n) | (y << (32 - n)));
  endfunction

  function automatic logic [63:0] s0(input logic [63:0] x);
    if (wide != 0) return ror(x, 1) ^ ror(x, 8) ^ (msk(x) >> 7);
    return ror(x, 7) ^ ror(x, 18) ^ (msk(x) >> 3);
  endfunction

  function automatic logic [63:0] s1(input logic [63:0] x);
    if (wide != 0) return ror(x, 19) ^ ror(x, 61) ^ (msk(x) >> 6);
    return ror(x, 17) ^ ror(x, 19) ^ (msk(x) >> 10);
  endfunction

  // textbook recurrence W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16]
  task automatic expand(input int b);
    for (int t = 0; t < 16; t++) sw[t] = bw[b][t];
    for (int t = 16; t < rounds; t++)
      sw[t] = msk(s1(sw[t-2]) + sw[t-7] + s0(sw[t-15]) + sw[t-16]);
  endtask

  task automatic check(input string name, input int c, input logic [63:0] got,
                       input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, c, got, exp);
    end
  endtask

  task automatic init_timeline();
    for (int c = 0; c < NC; c++) begin
      drst[c] = 1'b0; drun[c] = 1'b0;
      din[c]  = {$urandom, $urandom};
      ddly[c] = $urandom; dblk[c] = 8'($urandom);
      ev[c] = 1'b0; edone[c] = 1'b1; ezero[c] = 1'b0; ew[c] = '0; eout[c] = '0;
    end
  endtask

  task automatic clear_from(input int c);
    for (int k = c; k < NC; k++) begin
      ev[k] = 1'b0; edone[k] = 1'b1; ezero[k] = 1'b0;
    end
  endtask

  task automatic plan_rst(input int c);
    drst[c] = 1'b1;
    clear_from(c + 1);
    ezero[c+1] = 1'b1;
  endtask

  task automatic plan_run(input int r, input int d, input int ncfg);
    int n, first, last, c;
    n = (ncfg == 0) ? 1 : ncfg;
    drun[r] = 1'b1; ddly[r] = 32'(d); dblk[r] = 8'(ncfg);
    clear_from(r + 1);
    first = r + d + 2;
    last  = first + n * rounds - 1;
    for (int k = r + 1; k < last; k++) edone[k] = 1'b0;
    for (int b = 0; b < n; b++) begin
      expand(b);
      for (int t = 0; t < rounds; t++) begin
        c = first + b * rounds + t;
        ev[c] = 1'b1; ew[c] = sw[t];
        if (t < 16) din[c-1] = bw[b][t];
      end
    end
  endtask

  task automatic set_abc();
    for (int b = 0; b < 4; b++) for (int t = 0; t < 16; t++) bw[b][t] = '0;
    bw[0][0]  = (wide != 0) ? 64'h6162_6380_0000_0000 : 64'h6162_6380;
    bw[0][15] = 64'h18;
  endtask

  task automatic set_rand();
    for (int b = 0; b < 4; b++) for (int t = 0; t < 16; t++) bw[b][t] = msk({$urandom, $urandom});
  endtask

  // random runs, the last one aborted by a second run at a random point
  task automatic plan_random(input int start, output int end_c);
    int c, d, nb, n, r2;
    c = start;
    for (int i = 0; i < 3; i++) begin
      d = $urandom_range(0, 6); nb = $urandom_range(0, 3); n = (nb == 0) ? 1 : nb;
      set_rand(); plan_run(c, d, nb);
      c = c + d + 2 + n * rounds + $urandom_range(0, 5);
    end
    set_rand(); plan_run(c, $urandom_range(0, 4), 1);
    r2 = c + $urandom_range(1, 60);
    d = $urandom_range(0, 4); nb = $urandom_range(1, 2);
    set_rand(); plan_run(r2, d, nb);
    end_c = r2 + d + 2 + nb * rounds + 4;
  endtask

  task automatic run_phase(input int last_c);
    logic [63:0] hold, go;
    logic gv, gd;
    int dv, mv;
    hold = '0; dv = 0; mv = 0;
    for (int c = 0; c < NC; c++) begin
      if (ezero[c]) hold = '0;
      if (ev[c]) hold = ew[c];
      eout[c] = hold;
    end
    for (int c = 0; c <= last_c; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        gv = (wide != 0) ? valid_b : valid_a;
        gd = (wide != 0) ? done_b : done_a;
        go = (wide != 0) ? out_b : {32'h0, out_a};
        check("valid", c, 64'(gv), 64'(ev[c]));
        check("done", c, 64'(gd), 64'(edone[c]));
        check("out0", c, go, eout[c]);
        if (gv) dv++;
        if (ev[c]) mv++;
      end
      if (wide != 0) begin
        rst_b = drst[c]; run_b = drun[c]; in_b = din[c]; dly_b = ddly[c]; blk_b = dblk[c];
        rst_a = 1'b1; run_a = 1'b0;
      end else begin
        rst_a = drst[c]; run_a = drun[c]; in_a = din[c][31:0]; dly_a = ddly[c]; blk_a = dblk[c];
        rst_b = 1'b1; run_b = 1'b0;
      end
    end
    check("valid_count", last_c, 64'(dv), 64'(mv));
  endtask

  initial begin
    int fv, cnt, end_c;
    logic [63:0] acc;
    vectors = 0; errors = 0;
    rst_a = 1'b1; run_a = 1'b0; in_a = '0; dly_a = '0; blk_a = '0;
    rst_b = 1'b1; run_b = 1'b0; in_b = '0; dly_b = '0; blk_b = '0;

    // 32-bit / 64-round instance
    wide = 0; rounds = 64;
    init_timeline();
    plan_rst(0);
    set_abc(); plan_run(3, 0, 1);
    check("pin_abc32_w16", 21, ew[21], 64'h6162_6380);
    check("pin_abc32_w17", 22, ew[22], 64'h000F_0000);
    set_abc(); plan_run(75, 5, 1);
    fv = -1;
    for (int c = 76; c < 200 && fv < 0; c++) if (ev[c]) fv = c;
    check("pin_delay5_first", 75, 64'(fv), 64'(82));
    set_abc(); plan_run(150, 0, 2);
    cnt = 0; acc = '0;
    for (int c = 151; c <= 280; c++) if (ev[c]) cnt++;
    for (int c = 216; c <= 279; c++) acc = acc | ew[c];
    check("pin_two_block_count", 150, 64'(cnt), 64'(128));
    check("pin_zero_block", 216, acc, 64'h0);
    set_rand(); plan_run(290, 0, 1);
    set_rand(); plan_run(316, 0, 1);
    set_abc(); plan_run(390, 0, 1);
    plan_rst(398);
    set_abc(); plan_run(402, 0, 1);
    plan_random(475, end_c);
    run_phase(end_c);

    // 64-bit / 80-round instance
    wide = 1; rounds = 80;
    init_timeline();
    plan_rst(0);
    set_abc(); plan_run(3, 0, 1);
    check("pin_abc64_w16", 21, ew[21], 64'h6162_6380_0000_0000);
    check("pin_abc64_w17", 22, ew[22], 64'h0003_0000_0000_00C0);
    plan_random(95, end_c);
    run_phase(end_c);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
